store_commit_queue: RTL
=======================

# store_commit_queue

In-order store buffer between the issue stage and the data-memory interface. Each store is enqueued at issue with its ID, address, data and byte enables. Entries are marked committed, strictly in program order, when the ID manager's registered `store_retire` packet names them. Committed entries are drained to memory oldest-first over a valid/ready handshake. Issued stores are never squashed, so the block has no flush input.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2.
- ID_W, 3: width of instruction ID; equals LOG2_MAX_IDS.
- ADDR_W, 32: store address width.
- DATA_W, 32: store data width; byte-enable width is DATA_W/8.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- enq_valid  in  1  issue stage presents a store.
- enq_ready  out  1  queue not full; transfer when enq_valid & enq_ready.
- enq_id  in  ID_W  ID of the store being enqueued.
- enq_addr  in  ADDR_W  store address.
- enq_data  in  DATA_W  store data.
- enq_be  in  DATA_W/8  byte enables.
- store_retire_valid  in  1  registered retire packet valid; at most one store per cycle.
- store_retire_id  in  ID_W  ID of the retiring store.
- mem_valid  out  1  committed store available at head.
- mem_ready  in  1  memory accepts; transfer when mem_valid & mem_ready.
- mem_addr  out  ADDR_W  head entry address.
- mem_data  out  DATA_W  head entry data.
- mem_be  out  DATA_W/8  head entry byte enables.
- occupancy  out  log2(DEPTH)+1  entries held, committed or not.
- committed_pending  out  log2(DEPTH)+1  committed entries not yet drained.
- empty  out  1  occupancy == 0; used by fence/CSR logic as "all stores written".
- protocol_error  out  1  sticky retire-protocol violation flag.

## Operation
- Storage: DEPTH-entry array of {id, addr, data, be}. Written only on enqueue; no reset needed.
- Three pointers, each log2(DEPTH)+1 bits with the MSB used as a wrap bit:
  - head: oldest entry, next to drain.
  - commit: oldest uncommitted entry.
  - tail: next free slot.
- Invariant: head ≤ commit ≤ tail in modular order.
- Derived values:
  - occupancy = tail − head.
  - committed_pending = commit − head.
  - full: low bits of tail and head are equal and their MSBs differ.
- Enqueue: on enq_valid & enq_ready, write the entry at tail[low] and increment tail.
  - enq_ready = ~full. It does not depend on mem_ready in the same cycle, so a full queue rejects even while it is draining.
- Commit, on store_retire_valid:
  - If commit ≠ tail and store_retire_id == id[commit]: increment commit.
  - Otherwise: no pointer change and set protocol_error, which stays set until rst.
- Drain:
  - mem_valid = (commit ≠ head).
  - mem_addr, mem_data and mem_be are read combinationally from entry head[low].
  - On mem_valid & mem_ready, increment head.
  - While mem_valid is high and mem_ready is low, the payload is held stable.
- Simultaneous events:
  - Enqueue, commit and drain may all occur in the same cycle; each pointer updates independently.
  - A retire may only target an entry enqueued in an earlier cycle. A retire naming the entry being enqueued in the same cycle sees commit == tail and is flagged as a protocol error.
- Wrap-around: pointers wrap modulo 2·DEPTH; IDs wrap modulo 2^ID_W and are compared for equality only.

## Timing
- Reset values:
  - pointers: 0
  - occupancy: 0, committed_pending: 0
  - empty: 1, enq_ready: 1
  - mem_valid: 0
  - protocol_error: 0
- Enqueue → occupancy/empty updated: 1 cycle.
- Retire → mem_valid high: 1 cycle, i.e. the cycle after store_retire_valid, if the entry is the head.
- Drain acceptance → next entry on mem_*: next cycle; back-to-back drains give 1 store/cycle.
- Full recovery: enq_ready returns high the cycle after the drain handshake that frees a slot.
- rst asserted mid-operation: all pointers clear the next cycle; outstanding entries are discarded and mem_valid drops.

## Test plan
- Single store: enqueue id=2, addr=0x100, data=0xDEADBEEF, be=0xF, then retire id=2 one cycle later, mem_ready=1 → mem_valid high the cycle after the retire with those exact values; empty=1 the following cycle.
- Fill: 4 enqueues (ids 0–3) with no retires → occupancy=4, enq_ready=0, mem_valid=0. Retire id 0 and drain it → enq_ready=1 the next cycle.
- Backpressure: commit 3 stores with mem_ready=0 for 5 cycles → mem_valid stays 1 with head payload stable and committed_pending=3. Release mem_ready → 3 stores drain in order over 3 consecutive cycles.
- Wrap: stream 10 stores (ids 5,6,7,0,1,…) with continuous retire and drain → all 10 appear on mem_* in order; pointers wrap twice; protocol_error stays 0.
- Errors:
  - Retire with an empty queue → protocol_error=1, pointers unchanged.
  - Separately, retire id=4 when the commit entry has id=3 → protocol_error=1, committed_pending unchanged.
- Reset mid-stream: with occupancy=3 and committed_pending=2, assert rst → the next cycle shows occupancy=0, mem_valid=0, enq_ready=1, protocol_error=0.

Source files
------------

// File: rtl/store_commit_queue.sv
// In-order store buffer: stores enqueue at issue, commit in program order on
// retire packets, and drain oldest-first to the data-memory interface.
module store_commit_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ID_W   = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enq_valid,
  output logic                        enq_ready,
  input  logic [ID_W-1:0]             enq_id,
  input  logic [ADDR_W-1:0]           enq_addr,
  input  logic [DATA_W-1:0]           enq_data,
  input  logic [DATA_W/8-1:0]         enq_be,
  input  logic                        store_retire_valid,
  input  logic [ID_W-1:0]             store_retire_id,
  output logic                        mem_valid,
  input  logic                        mem_ready,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_data,
  output logic [DATA_W/8-1:0]         mem_be,
  output logic [$clog2(DEPTH):0]      occupancy,
  output logic [$clog2(DEPTH):0]      committed_pending,
  output logic                        empty,
  output logic                        protocol_error
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [ID_W-1:0]   id_mem   [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [BE_W-1:0]   be_mem   [DEPTH];

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0] head;
  logic [PTR_W:0] commit;
  logic [PTR_W:0] tail;

  logic full;
  logic enq_fire;
  logic drain_fire;
  logic commit_ok;
  logic retire_bad;

  always_comb begin
    full       = (tail[PTR_W-1:0] == head[PTR_W-1:0]) && (tail[PTR_W] != head[PTR_W]);
    enq_ready  = ~full;
    enq_fire   = enq_valid & enq_ready;
    mem_valid  = (commit != head);
    drain_fire = mem_valid & mem_ready;
    // A same-cycle enqueue is not yet visible here, so retiring it is an error.
    commit_ok  = store_retire_valid && (commit != tail) &&
                 (store_retire_id == id_mem[commit[PTR_W-1:0]]);
    retire_bad = store_retire_valid & ~commit_ok;
  end

  always_comb begin
    mem_addr          = addr_mem[head[PTR_W-1:0]];
    mem_data          = data_mem[head[PTR_W-1:0]];
    mem_be            = be_mem[head[PTR_W-1:0]];
    occupancy         = tail - head;
    committed_pending = commit - head;
    empty             = (tail == head);
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      id_mem[tail[PTR_W-1:0]]   <= enq_id;
      addr_mem[tail[PTR_W-1:0]] <= enq_addr;
      data_mem[tail[PTR_W-1:0]] <= enq_data;
      be_mem[tail[PTR_W-1:0]]   <= enq_be;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      commit         <= '0;
      tail           <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (enq_fire)   tail   <= tail + PTR_ONE;
      if (commit_ok)  commit <= commit + PTR_ONE;
      if (drain_fire) head   <= head + PTR_ONE;
      if (retire_bad) protocol_error <= 1'b1;
    end
  end

endmodule
